// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data memory answering RV32I load/store requests
//
// Accepts one load/store request at a time, waits LATENCY cycles, then presents
// a held response until the core takes it. Memory contents survive reset.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE, low during reset)
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   req_funct3            RV32I width/sign selector
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data, 0 for stores and errors
//   resp_err              misaligned, out of range or illegal funct3
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic        enter_resp;
  logic [3:0]  cnt;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_funct3;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=0 the response is produced on the accept edge itself, before
  // the capture registers hold the request, so the live inputs are used then.
  logic        op_we;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [2:0]  op_funct3;
  logic        op_err;
  logic [AW-1:0] widx;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  assign req_ready  = (state == S_IDLE) && !rst;
  assign resp_valid = (state == S_RESP);

  assign op_we     = (state == S_IDLE) ? req_we     : cap_we;
  assign op_addr   = (state == S_IDLE) ? req_addr   : cap_addr;
  assign op_wdata  = (state == S_IDLE) ? req_wdata  : cap_wdata;
  assign op_funct3 = (state == S_IDLE) ? req_funct3 : cap_funct3;

  assign op_err = ((op_funct3[1:0] == 2'b01) && op_addr[0])
               || ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00))
               || (op_funct3[1:0] == 2'b11)
               || (op_funct3 == 3'b110)
               || (op_we && op_funct3[2])
               || (op_addr[31:2] >= DEPTH_LIM);

  assign widx     = op_addr[AW+1:2];
  assign rd_word  = mem[widx];
  assign rd_shift = rd_word >> {op_addr[1:0], 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    be      = 4'b0000;
    st_data = op_wdata;
    case (op_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << op_addr[1:0];
        st_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be      = op_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{op_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    load_val = 32'h0;
    case (op_funct3)
      3'b000: load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001: load_val = {{16{rd_half[15]}}, rd_half};
      3'b010: load_val = rd_word;
      3'b100: load_val = {24'h0, rd_byte};
      3'b101: load_val = {16'h0, rd_half};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        cap_we     <= req_we;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
        cap_funct3 <= req_funct3;
        cnt        <= LAT_LOAD;
      end
      if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        resp_err   <= op_err;
        resp_rdata <= (op_err || op_we) ? 32'h0 : load_val;
      end
    end
  end

  // Storage has no reset; a write only happens on the edge that commits the response.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        rst0;
  logic        req_valid0;
  logic        req_ready0;
  logic        req_we0;
  logic [31:0] req_addr0;
  logic [31:0] req_wdata0;
  logic [2:0]  req_funct30;
  logic        resp_valid0;
  logic        resp_ready0;
  logic [31:0] resp_rdata0;
  logic        resp_err0;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst0),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request bus: the captured request must be used from now on.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_funct3 = 3'($urandom);
  endtask

  task automatic finish_resp(input int hold, input bit early);
    int n = 0;
    logic [32:0] e;
    logic [31:0] r0;
    logic        er0;
    if (early) resp_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
    chk("latency", 32'(n), 32'(LAT + 1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
    chk("rdata", resp_rdata, e[31:0]);
    chk("err", {31'b0, resp_err}, {31'b0, e[32]});
    r0 = resp_rdata; er0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, r0);
      chk("hold_err", {31'b0, resp_err}, {31'b0, er0});
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("valid_drop", {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                        input int hold = 0, input bit early = 1'b0);
    exp_q.push_back({exp_err, exp_rd});
    start_req(we, addr, wdata, f3);
    finish_resp(hold, early);
  endtask

  task automatic do_req0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [31:0] exp_rd);
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_funct30 = f3;
    chk("l0_req_ready", {31'b0, req_ready0}, 32'd1);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("l0_resp_valid_1cyc", {31'b0, resp_valid0}, 32'd1);
    chk("l0_rdata", resp_rdata0, exp_rd);
    chk("l0_err", {31'b0, resp_err0}, 32'd0);
    resp_ready0 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready0 = 1'b0;
    chk("l0_valid_drop", {31'b0, resp_valid0}, 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1; rst0 = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0; resp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_funct30 = 0; resp_ready0 = 0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    rst = 1'b0; rst0 = 1'b0;
    #1;
    chk("rst_release_ready", {31'b0, req_ready}, 32'd1);

    do_req(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
    do_req(0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 0);
    do_req(0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 0, 0, 1'b1);
    do_req(0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 0);
    do_req(0, 32'h10, 32'h0, 3'b101, 32'h0000BEEF, 0);

    do_req(1, 32'h11, 32'h12345678, 3'b000, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 3'b010, 32'hDEAD78EF, 0);

    do_req(0, 32'h12, 32'h0, 3'b010, 32'h0, 1);
    do_req(1, 32'h13, 32'h0000AAAA, 3'b001, 32'h0, 1);
    do_req(0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
    do_req(0, 32'h400, 32'h0, 3'b010, 32'h0, 1);
    do_req(1, 32'h10, 32'h55555555, 3'b100, 32'h0, 1);
    do_req(0, 32'h10, 32'h0, 3'b010, 32'hDEAD78EF, 0, 5);

    do_req(1, 32'h16, 32'h0000ABCD, 3'b001, 32'h0, 0, 0, 1'b1);
    do_req(0, 32'h16, 32'h0, 3'b001, 32'hFFFFABCD, 0);
    do_req(0, 32'h14, 32'h0, 3'b110, 32'h0, 1);

    // Reset while waiting: the store must be abandoned.
    do_req(1, 32'h20, 32'h11111111, 3'b010, 32'h0, 0);
    start_req(1, 32'h20, 32'h22222222, 3'b010);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad++;
    end
    chk("wait_rst_no_resp", 32'(bad), 32'd0);
    do_req(0, 32'h20, 32'h0, 3'b010, 32'h11111111, 0);

    // Reset while responding: the committed store must persist.
    start_req(1, 32'h24, 32'h33333333, 3'b010);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
    chk("resp_rst_reached", {31'b0, resp_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("resp_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("resp_rst_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("resp_rst_ready_after", {31'b0, req_ready}, 32'd1);
    do_req(0, 32'h24, 32'h0, 3'b010, 32'h33333333, 0);

    do_req0(1, 32'h8, 32'hCAFEF00D, 3'b010, 32'h0);
    do_req0(0, 32'h8, 32'h0, 3'b010, 32'hCAFEF00D);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
